// File: rtl/muldiv_iter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// muldiv_iter : iterative radix-2 RV32M multiply/divide unit. Rev 1.0
// Optional MULDIV_FAST_MUL_EN : single-cycle 33x33 multiplier for MUL* ops.
// ----------------------------------------------------------------------------
module muldiv_iter #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [TAG_W-1:0] req_tag,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_data,
  output logic [TAG_W-1:0] resp_tag,
  output logic             busy
);
  localparam logic [1:0]       S_IDLE    = 2'd0;
  localparam logic [1:0]       S_CALC    = 2'd1;
  localparam logic [1:0]       S_DONE    = 2'd2;
  localparam logic [4:0]       LAST_STEP = 5'(WIDTH - 1);
  localparam logic [WIDTH-1:0] INT_MIN   = {1'b1, {(WIDTH-1){1'b0}}};

  logic [1:0]         state, state_nxt;
  logic [4:0]         cnt;
  logic [2:0]         op_q;
  logic               neg_q;
  logic [WIDTH-1:0]   b_q, rem_q;
  logic [2*WIDTH-1:0] prod_q;

  logic               accept, a_signed, b_signed, a_neg, b_neg, neg_in;
  logic               special, fast;
  logic [WIDTH-1:0]   a_mag, b_mag, special_res, fast_res;

  assign accept = req_valid && req_ready && !flush;

  always_comb begin
    a_signed    = (req_op == 3'd1) || (req_op == 3'd2) || (req_op == 3'd4) || (req_op == 3'd6);
    b_signed    = (req_op == 3'd1) || (req_op == 3'd4) || (req_op == 3'd6);
    a_neg       = a_signed && req_a[WIDTH-1];
    b_neg       = b_signed && req_b[WIDTH-1];
    a_mag       = a_neg ? -req_a : req_a;
    b_mag       = b_neg ? -req_b : req_b;
    // remainder sign follows the dividend only
    neg_in      = (req_op == 3'd6) ? a_neg : (a_neg ^ b_neg);
    special     = 1'b0;
    special_res = '0;
    if (req_op[2] && req_b == '0) begin
      special     = 1'b1;
      special_res = req_op[1] ? req_a : '1;
    end else if (req_op[2] && !req_op[0] && req_a == INT_MIN && req_b == '1) begin
      special     = 1'b1;
      special_res = req_op[1] ? '0 : INT_MIN;
    end
  end

`ifdef MULDIV_FAST_MUL_EN
  logic signed [WIDTH:0]     fa, fb;
  logic signed [2*WIDTH-1:0] fp;
  always_comb begin
    fa       = {a_neg, req_a};
    fb       = {b_neg, req_b};
    fp       = (2*WIDTH)'(fa) * (2*WIDTH)'(fb);
    fast     = !req_op[2];
    fast_res = (req_op == 3'd0) ? fp[WIDTH-1:0] : fp[2*WIDTH-1:WIDTH];
  end
`else
  assign fast     = 1'b0;
  assign fast_res = '0;
`endif

  logic [WIDTH:0]     mul_sum, rem_shift;
  logic [2*WIDTH-1:0] mul_nxt, prod_fix;
  logic               div_ge;
  logic [WIDTH-1:0]   rem_nxt, quo_nxt, mul_sel, div_sel, final_res;

  // one shift-add / restoring step; final_res is only used on the last step
  always_comb begin
    mul_sum   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, b_q} : '0);
    mul_nxt   = {mul_sum, prod_q[WIDTH-1:1]};
    rem_shift = {rem_q, prod_q[WIDTH-1]};
    div_ge    = rem_shift >= {1'b0, b_q};
    rem_nxt   = div_ge ? (rem_shift[WIDTH-1:0] - b_q) : rem_shift[WIDTH-1:0];
    quo_nxt   = {prod_q[WIDTH-2:0], div_ge};
    prod_fix  = neg_q ? -mul_nxt : mul_nxt;
    mul_sel   = (op_q == 3'd0) ? prod_fix[WIDTH-1:0] : prod_fix[2*WIDTH-1:WIDTH];
    div_sel   = op_q[1] ? rem_nxt : quo_nxt;
    if (neg_q) div_sel = -div_sel;
    final_res = op_q[2] ? div_sel : mul_sel;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = (special || fast) ? S_DONE : S_CALC;
      S_CALC:  if (cnt == LAST_STEP) state_nxt = S_DONE;
      S_DONE:  if (resp_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (flush) state_nxt = S_IDLE;
  end

  always_comb begin
    req_ready  = (state == S_IDLE);
    resp_valid = (state == S_DONE);
    busy       = (state != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      op_q      <= '0;
      neg_q     <= 1'b0;
      b_q       <= '0;
      rem_q     <= '0;
      prod_q    <= '0;
      resp_data <= '0;
      resp_tag  <= '0;
    end else if (state == S_IDLE) begin
      if (accept) begin
        cnt      <= '0;
        op_q     <= req_op;
        neg_q    <= neg_in;
        b_q      <= b_mag;
        rem_q    <= '0;
        prod_q   <= {{WIDTH{1'b0}}, a_mag};
        resp_tag <= req_tag;
        if (special)   resp_data <= special_res;
        else if (fast) resp_data <= fast_res;
      end
    end else if (state == S_CALC) begin
      cnt <= cnt + 5'd1;
      if (op_q[2]) begin
        prod_q[WIDTH-1:0] <= quo_nxt;
        rem_q             <= rem_nxt;
      end else begin
        prod_q <= mul_nxt;
      end
      if (cnt == LAST_STEP) resp_data <= final_res;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_muldiv_iter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_muldiv_iter : scoreboard bench for muldiv_iter with a 64-bit arithmetic model.
// ----------------------------------------------------------------------------
module tb_muldiv_iter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_op = '0;
  logic [31:0] req_a = '0;
  logic [31:0] req_b = '0;
  logic [4:0]  req_tag = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_data;
  logic [4:0]  resp_tag;
  logic        busy;

  muldiv_iter #(.WIDTH(32), .TAG_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_tag(resp_tag), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  tag;
    int          acc;
    int          lat;
  } exp_t;
  exp_t sb[$];

  int passed = 0;
  int total  = 0;
  int ready_mode = 0;
  int last_hs = -1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    total++;
    $display("FAIL %s: bound expired or unexpected event", name);
  endtask

  function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    longint sa, sb2, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a)); sb2 = longint'($signed(b));
    ua = longint'(a);          ub  = longint'(b);
    p  = '0;
    case (op)
      3'd0: begin p = sa * sb2; return p[31:0]; end
      3'd1: begin p = sa * sb2; return p[63:32]; end
      3'd2: begin p = sa * ub;  return p[63:32]; end
      3'd3: begin p = ua * ub;  return p[63:32]; end
      3'd4: begin if (b == 0) return '1; p = sa / sb2; return p[31:0]; end
      3'd5: begin if (b == 0) return '1; p = ua / ub;  return p[31:0]; end
      3'd6: begin if (b == 0) return a;  p = sa % sb2; return p[31:0]; end
      default: begin if (b == 0) return a; p = ua % ub; return p[31:0]; end
    endcase
  endfunction

  function automatic int exp_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op[2] && b == 0) return 1;
    if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef MULDIV_FAST_MUL_EN
    if (!op[2]) return 1;
`endif
    return 33;
  endfunction

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(5))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(15));
      default: return $urandom;
    endcase
  endfunction

  initial forever begin
    @(posedge clk); #1;
    case (ready_mode)
      0:       resp_ready = 1'b1;
      1:       resp_ready = ($urandom_range(3) != 0);
      default: resp_ready = 1'b0;
    endcase
  end

  // monitor: latency on first resp_valid, data/tag every DONE cycle, pop on handshake
  bit prev_v = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) prev_v = 1'b0;
    else begin
      if (resp_valid && !prev_v) begin
        if (sb.size() == 0) fail_now("spurious_resp");
        else check("latency", 64'(cyc - sb[0].acc), 64'(sb[0].lat));
      end
      if (resp_valid && sb.size() != 0) begin
        check("resp_data", resp_data, sb[0].data);
        check("resp_tag", resp_tag, sb[0].tag);
        check("req_ready_in_done", req_ready, 0);
        if (resp_ready) begin
          void'(sb.pop_front());
          last_hs = cyc;
        end
      end
      prev_v = resp_valid;
    end
  end

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] tag, input bit push, input logic [31:0] exp_data,
                       output int acc);
    exp_t e;
    @(posedge clk); #1;
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_tag = tag;
    acc = -1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (req_ready) begin acc = cyc; break; end
    end
    if (acc < 0) fail_now("accept_timeout");
    else if (push) begin
      e.data = exp_data; e.tag = tag; e.acc = acc; e.lat = exp_lat(op, a, b);
      sb.push_back(e);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 3000 && sb.size() != 0; n++) @(negedge clk);
    if (sb.size() != 0) begin
      fail_now("drain_timeout");
      sb.delete();
    end
  endtask

  // {op, a, b, expected}
  logic [98:0] dir [15] = '{
    {3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB},
    {3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000},
    {3'd3, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000},
    {3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF},
    {3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD},
    {3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF},
    {3'd5, 32'd100,       32'd7,         32'd14},
    {3'd7, 32'd100,       32'd7,         32'd2},
    {3'd5, 32'd5,         32'd0,         32'hFFFF_FFFF},
    {3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000},
    {3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000},
    {3'd7, 32'd5,         32'd0,         32'd5},
    {3'd4, 32'd7,         32'd0,         32'hFFFF_FFFF},
    {3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE},
    {3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000}
  };

  initial begin
    int acc;
    bit seen;
    logic [98:0] v;
    logic [2:0]  op;
    logic [31:0] a, b;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", req_ready, 1);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_data", resp_data, 0);
    check("rst_resp_tag", resp_tag, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;

    ready_mode = 0;
    for (int i = 0; i < 15; i++) begin
      v = dir[i];
      issue(v[98:96], v[95:64], v[63:32], 5'($urandom), 1'b1, v[31:0], acc);
    end
    drain();

    ready_mode = 1;
    for (int i = 0; i < 150; i++) begin
      op = 3'($urandom_range(7));
      a  = rnd_operand();
      b  = rnd_operand();
      issue(op, a, b, 5'($urandom), 1'b1, ref_model(op, a, b), acc);
    end
    drain();

    // backpressure in DONE, then back-to-back accept after the handshake
    ready_mode = 2;
    issue(3'd5, 32'd100, 32'd7, 5'h15, 1'b1, 32'd14, acc);
    seen = 1'b0;
    for (int n = 0; n < 100 && !seen; n++) begin
      @(negedge clk);
      seen = resp_valid;
    end
    if (!seen) fail_now("bp_wait_valid");
    repeat (10) begin
      @(negedge clk);
      check("bp_req_ready", req_ready, 0);
      check("bp_resp_valid", resp_valid, 1);
    end
    ready_mode = 0;
    issue(3'd7, 32'd100, 32'd7, 5'h0A, 1'b1, 32'd2, acc);
    check("accept_after_handshake", 64'(acc), 64'(last_hs + 1));
    drain();

    // flush during CALC iteration 10
    issue(3'd4, 32'h1234_5678, 32'd3, 5'h03, 1'b0, 32'd0, acc);
    repeat (10) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    check("flush_busy", busy, 0);
    check("flush_resp_valid", resp_valid, 0);
    check("flush_req_ready", req_ready, 1);
    repeat (40) @(negedge clk);

    // flush in the same cycle as a request cancels it
    @(posedge clk); #1;
    req_valid = 1'b1; req_op = 3'd5; req_a = 32'd9; req_b = 32'd0; flush = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    check("flush_accept_busy", busy, 0);
    repeat (5) @(negedge clk);

    // asynchronous reset mid-CALC
    issue(3'd6, 32'hDEAD_BEEF, 32'd13, 5'h1F, 1'b0, 32'd0, acc);
    repeat (5) @(posedge clk);
    #1 check("calc_busy", busy, 1);
    #1 rst_n = 1'b0;
    #1;
    check("arst_req_ready", req_ready, 1);
    check("arst_resp_valid", resp_valid, 0);
    check("arst_resp_data", resp_data, 0);
    check("arst_resp_tag", resp_tag, 0);
    check("arst_busy", busy, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    issue(3'd5, 32'd100, 32'd7, 5'h07, 1'b1, 32'd14, acc);
    drain();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #5_000_000;
    fail_now("watchdog");
    $display("%0d/%0d checks passed", passed, total);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/muldiv_iter.md
Name: muldiv_iter

Overview:
- Iterative multi-cycle multiply/divide unit: the sequential execution path for the M-extension operations the single-cycle ALU cannot close timing on.
- Decode issues an operation over a valid/ready request channel. The unit computes it over up to 33 cycles and returns the result over a valid/ready response channel to the writeback mux.
- Full RV32M semantics: signed, unsigned and mixed variants, with architecturally defined divide-by-zero and overflow results.

Parameters:
- WIDTH, 32, operand/result width; only 32 is supported.
- TAG_W, 5, width of the opaque tag carried from request to response (destination register index).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- flush  input  1  abort any in-flight operation; synchronous.
- req_valid  input  1  request present.
- req_ready  output  1  unit can accept a request.
- req_op  input  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- req_a  input  WIDTH  operand 1 (rs1).
- req_b  input  WIDTH  operand 2 (rs2).
- req_tag  input  TAG_W  tag returned with the result.
- resp_valid  output  1  result present.
- resp_ready  input  1  consumer accepts result.
- resp_data  output  WIDTH  result.
- resp_tag  output  TAG_W  tag of the result.
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE, counter 0. Outputs: req_ready 1, resp_valid 0, resp_data 0, resp_tag 0, busy 0.
- States: IDLE, CALC, DONE.
- req_ready = (state == IDLE). Accept = req_valid && req_ready. On accept, capture op, tag and operand magnitudes; latch the sign of each result.
- IDLE -> CALC on accept, counter loaded with 0. IDLE -> DONE directly on accept for the special cases below.
- CALC: one radix-2 step per cycle for 32 cycles.
  - Multiply: shift-add into a 64-bit product.
  - Divide: restoring step producing one quotient bit and updating the 33-bit partial remainder.
  - After the step with counter == 31, apply sign correction and go to DONE.
- DONE: resp_valid = 1; resp_data and resp_tag held stable until resp_valid && resp_ready, then return to IDLE.
- Latency, for an accept in cycle N with no backpressure:
  - Normal operation: resp_valid is first high in cycle N+33.
  - Special case: resp_valid is first high in cycle N+1.
- Signedness:
  - MULH: both operands signed.
  - MULHSU: a signed, b unsigned.
  - MULHU, DIVU, REMU: unsigned.
  - DIV, REM: both operands signed.
  - Magnitudes are taken up front and the result is negated at the end when the signs differ. The REM sign follows the dividend.
- Result selection: MUL returns product[31:0]; MULH, MULHSU and MULHU return product[63:32]. Results are truncated, never saturated.
- Special cases (no iteration, DONE next cycle):
  - b == 0: DIV/DIVU -> 0xFFFFFFFF; REM/REMU -> a.
  - DIV with a == 0x80000000 and b == 0xFFFFFFFF -> 0x80000000; the matching REM -> 0.
- flush: returns the unit to IDLE next cycle from any state and drops the result; resp_valid is 0 the next cycle. Flush in the same cycle as an accept cancels that request.
- No new request is accepted while in DONE, even if resp_ready is high in the same cycle. A new accept is possible in the cycle after the handshake.
- Reset mid-operation discards all state; no response is produced.

Optional Feature:
- Macro MULDIV_FAST_MUL_EN.
- Defined: the four multiply ops use a single-cycle 33x33 signed multiplier. IDLE -> DONE on accept; resp_valid is high in cycle N+1. Divide ops are unchanged.
- Undefined: multiplies iterate through CALC, 33-cycle latency; no hardware multiplier is inferred.

Test Plan:
- MUL a=7, b=0xFFFFFFFD (-3) -> resp_data 0xFFFFFFEB; resp_valid rises exactly 33 cycles after accept (1 cycle with MULDIV_FAST_MUL_EN); resp_tag echoes req_tag.
- MULH a=b=0x80000000 -> 0x40000000; MULHU same operands -> 0x40000000; MULHSU a=0xFFFFFFFF, b=2 -> 0xFFFFFFFF.
- DIV a=0xFFFFFFF9 (-7), b=2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU a=100, b=7 -> 14; REMU -> 2.
- DIVU a=5, b=0 -> 0xFFFFFFFF after 1 cycle; REM a=0x80000000, b=0xFFFFFFFF -> 0; DIV with the same operands -> 0x80000000.
- Backpressure: resp_ready held 0 for 10 cycles in DONE -> resp_data/resp_tag stable, req_ready 0; handshake completes, then a new request is accepted the next cycle.
- flush in CALC at iteration 10 -> IDLE next cycle, busy 0, resp_valid never asserted. Separately, rst_n pulsed low mid-CALC -> all outputs at reset values asynchronously.
